// File: rtl/key_select_debouncer.sv
// -----------------------------------------------------------------------------
// key_select_debouncer
//   Conditions raw active-low pushbuttons into clean, synchronised, active-high
//   levels plus one-cycle press/release strobes. KEY_LEVEL is the select code
//   for the downstream mux / seven-segment path. Every key is an independent
//   channel: two-flop synchroniser, stability counter, registered strobes.
//
// Ports
//   CLOCK_50     in   1          system clock, rising edge
//   RESETN       in   1          asynchronous active-low reset
//   KEY          in   NUM_KEYS   raw pushbuttons, async, active-low
//   KEY_LEVEL    out  NUM_KEYS   debounced level, active-high
//   KEY_PRESS    out  NUM_KEYS   1-cycle pulse on KEY_LEVEL 0->1
//   KEY_RELEASE  out  NUM_KEYS   1-cycle pulse on KEY_LEVEL 1->0
//   SEL_CHANGE   out  1          1-cycle pulse when any KEY_LEVEL bit changes
//
// Parameters
//   NUM_KEYS         number of keys
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles to accept a change (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module key_select_debouncer #(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                CLOCK_50,
   input  logic                RESETN,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] KEY_LEVEL,
   output logic [NUM_KEYS-1:0] KEY_PRESS,
   output logic [NUM_KEYS-1:0] KEY_RELEASE,
   output logic                SEL_CHANGE
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] sync_1;
   logic [NUM_KEYS-1:0] sync_2;
   logic [NUM_KEYS-1:0] key_act;
   logic [NUM_KEYS-1:0] accept;
   logic [CNT_W-1:0]    cnt [NUM_KEYS];

   // A change is accepted on the edge where the synchronised level still
   // disagrees with KEY_LEVEL and the counter has reached its terminal value.
   always_comb begin
      key_act = ~sync_2;
      accept  = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         accept[i] = (key_act[i] != KEY_LEVEL[i]) && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         // Synchroniser resets to "released" so a held key is seen as a fresh press.
         sync_1      <= '1;
         sync_2      <= '1;
         KEY_LEVEL   <= '0;
         KEY_PRESS   <= '0;
         KEY_RELEASE <= '0;
         SEL_CHANGE  <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync_1 <= KEY;
         sync_2 <= sync_1;
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_act[i] == KEY_LEVEL[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               KEY_LEVEL[i] <= key_act[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         KEY_PRESS   <= accept & key_act;
         KEY_RELEASE <= accept & ~key_act;
         SEL_CHANGE  <= |accept;
      end
   end

endmodule

// File: tb/tb_key_select_debouncer.sv
module tb_key_select_debouncer;

   localparam int NK = 3;

   logic          clk;
   logic          resetn;
   logic [NK-1:0] key;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic          sel_change;

   int errors;
   int checks;
   logic [NK-1:0] exp_lvl;

   typedef struct {
      logic [NK-1:0] key;
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
   } vec_t;

   key_select_debouncer #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .CLOCK_50   (clk),
      .RESETN     (resetn),
      .KEY        (key),
      .KEY_LEVEL  (key_level),
      .KEY_PRESS  (key_press),
      .KEY_RELEASE(key_release),
      .SEL_CHANGE (sel_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                          input logic [NK-1:0] rel, input logic sel);
      chk({tag, ".level"},   key_level,   lvl);
      chk({tag, ".press"},   key_press,   prs);
      chk({tag, ".release"}, key_release, rel);
      chk({tag, ".sel"},     {2'b00, sel_change}, {2'b00, sel});
   endtask

   // Key change lands before edge E1; outputs move after edge E1+5 (c == 5).
   task automatic apply_vec(input string tag, input vec_t v);
      key = v.key;
      for (int c = 0; c <= 7; c++) begin
         step();
         if (c < 5)
            chk_all({tag, ".hold"}, exp_lvl, '0, '0, 1'b0);
         else if (c == 5)
            chk_all({tag, ".accept"}, v.lvl, v.prs, v.rel, |(v.prs | v.rel));
         else
            chk_all({tag, ".after"}, v.lvl, '0, '0, 1'b0);
      end
      exp_lvl = v.lvl;
   endtask

   vec_t sweep [8];
   int   npress;

   initial begin
      errors  = 0;
      checks  = 0;
      exp_lvl = '0;

      // Reset with all keys pressed: outputs stay low through clock edges.
      resetn = 1'b0;
      key    = 3'b000;
      #1;
      chk_all("reset.async", 3'b000, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk_all("reset.held", 3'b000, 3'b000, 3'b000, 1'b0);
      end
      key = 3'b111;
      step();
      resetn = 1'b1;

      // Clean press / release, simultaneous, then the select sweep.
      sweep[0] = '{key: 3'b110, lvl: 3'b001, prs: 3'b001, rel: 3'b000};
      sweep[1] = '{key: 3'b111, lvl: 3'b000, prs: 3'b000, rel: 3'b001};
      sweep[2] = '{key: 3'b010, lvl: 3'b101, prs: 3'b101, rel: 3'b000};
      sweep[3] = '{key: 3'b111, lvl: 3'b000, prs: 3'b000, rel: 3'b101};
      for (int i = 0; i < 4; i++) apply_vec("basic", sweep[i]);

      // Bounce on KEY[1]: low 3, high 1, then low held. Accept 4 mismatches after last bounce.
      npress = 0;
      for (int e = 1; e <= 14; e++) begin
         key = (e == 4) ? 3'b111 : 3'b101;
         step();
         if (key_press[1]) npress++;
         if (e < 10)
            chk_all("bounce.hold", 3'b000, 3'b000, 3'b000, 1'b0);
         else if (e == 10)
            chk_all("bounce.accept", 3'b010, 3'b010, 3'b000, 1'b1);
         else
            chk_all("bounce.after", 3'b010, 3'b000, 3'b000, 1'b0);
      end
      chk("bounce.npress", npress[NK-1:0], 3'd1);
      exp_lvl = 3'b010;
      apply_vec("bounce.rel", '{key: 3'b111, lvl: 3'b000, prs: 3'b000, rel: 3'b010});

      // Reset mid-count with KEY[2] held through reset release.
      apply_vec("rmid.pre", '{key: 3'b110, lvl: 3'b001, prs: 3'b001, rel: 3'b000});
      key = 3'b010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all("rmid.count", 3'b001, 3'b000, 3'b000, 1'b0);
      end
      resetn = 1'b0;
      #1;
      chk_all("rmid.async", 3'b000, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_all("rmid.held", 3'b000, 3'b000, 3'b000, 1'b0);
      end
      resetn  = 1'b1;
      exp_lvl = 3'b000;
      apply_vec("rmid.post", '{key: 3'b010, lvl: 3'b101, prs: 3'b101, rel: 3'b000});
      apply_vec("rmid.rel",  '{key: 3'b111, lvl: 3'b000, prs: 3'b000, rel: 3'b101});

      // Select sweep codes 1..5 then back to 0.
      sweep[0] = '{key: 3'b110, lvl: 3'b001, prs: 3'b001, rel: 3'b000};
      sweep[1] = '{key: 3'b101, lvl: 3'b010, prs: 3'b010, rel: 3'b001};
      sweep[2] = '{key: 3'b100, lvl: 3'b011, prs: 3'b001, rel: 3'b000};
      sweep[3] = '{key: 3'b011, lvl: 3'b100, prs: 3'b100, rel: 3'b011};
      sweep[4] = '{key: 3'b010, lvl: 3'b101, prs: 3'b001, rel: 3'b000};
      sweep[5] = '{key: 3'b111, lvl: 3'b000, prs: 3'b000, rel: 3'b101};
      for (int i = 0; i < 6; i++) apply_vec("sweep", sweep[i]);

      // Held key: one press, then no repeats.
      apply_vec("held", '{key: 3'b011, lvl: 3'b100, prs: 3'b100, rel: 3'b000});
      for (int i = 0; i < 20; i++) begin
         step();
         chk_all("held.stay", 3'b100, 3'b000, 3'b000, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
